// File: rtl/keypad_debouncer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_debouncer_pkg                                          |
// | Purpose  : Shared input_control constants: key count, key-code width,    |
// |            default debounce depth and the debouncer FSM state encoding.  |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package keypad_debouncer_pkg;

  localparam int c_n_keys          = 10;
  localparam int c_key_code_w      = 4;
  localparam int c_debounce_cycles = 4;

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle    = 2'd0;
  localparam state_t c_st_arm     = 2'd1;
  localparam state_t c_st_held    = 2'd2;
  localparam state_t c_st_release = 2'd3;

endpackage : keypad_debouncer_pkg
`default_nettype wire

// File: rtl/keypad_debouncer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_debouncer_if                                           |
// | Purpose  : Bundles the raw key lines and the debounced key outputs.      |
// | Ports    : raw_keys  - asynchronous switch lines, active-high            |
// |            keypad    - debounced one-hot key level                       |
// |            key_valid - one-cycle accept pulse                            |
// |            key_code  - binary index of accepted key                      |
// |            multi_err - one-cycle multi-key pulse                         |
// |            modport master : the debouncer (drives the key outputs)       |
// |            modport slave  : the environment (drives raw_keys)            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface keypad_debouncer_if
  import keypad_debouncer_pkg::*;
#(
  parameter int N_KEYS     = c_n_keys,
  parameter int KEY_CODE_W = c_key_code_w
);

  logic [N_KEYS-1:0]     raw_keys;
  logic [N_KEYS-1:0]     keypad;
  logic                  key_valid;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  multi_err;

  modport master (
    input  raw_keys,
    output keypad,
    output key_valid,
    output key_code,
    output multi_err
  );

  modport slave (
    output raw_keys,
    input  keypad,
    input  key_valid,
    input  key_code,
    input  multi_err
  );

endinterface : keypad_debouncer_if
`default_nettype wire

// File: rtl/keypad_debouncer_sync2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_debouncer_sync2                                        |
// | Purpose  : Parameterised two-flop synchroniser with asynchronous         |
// |            active-low clear; reusable for any input_control line.        |
// | Ports    : clk     - system clock                                        |
// |            clear_n - asynchronous active-low clear                       |
// |            d       - asynchronous input bus (WIDTH bits)                 |
// |            q       - synchronised output bus (WIDTH bits)                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module keypad_debouncer_sync2 #(
  parameter int WIDTH = 1
) (
  input  wire logic             clk,
  input  wire logic             clear_n,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : keypad_debouncer_sync2
`default_nettype wire

// File: rtl/keypad_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_debouncer                                              |
// | Purpose  : Synchronises and debounces the raw keypad lines, rejects      |
// |            multi-key presses and delivers a clean one-hot key level,     |
// |            an accept pulse and a binary key code to counter_nr.          |
// | Ports    : clk     - system clock, rising edge                           |
// |            clear_n - asynchronous active-low reset                       |
// |            bus     - keypad_debouncer_if.master (raw_keys in; keypad,    |
// |                      key_valid, key_code, multi_err out)                 |
// | Options  : KEYPAD_REPEAT_EN - auto-repeat every REPEAT_CYCLES while held |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module keypad_debouncer
  import keypad_debouncer_pkg::*;
#(
  parameter int N_KEYS          = c_n_keys,
  parameter int DEBOUNCE_CYCLES = c_debounce_cycles,
  parameter int REPEAT_CYCLES   = 50
) (
  input wire logic            clk,
  input wire logic            clear_n,
  keypad_debouncer_if.master  bus
);

  localparam int c_cnt_max = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max) + 1;

  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [c_cnt_w-1:0] c_rpt_last = c_cnt_w'(REPEAT_CYCLES - 1);
`endif

  // Registered state
  state_t                  r_state;
  logic [N_KEYS-1:0]       r_cand;
  logic [c_cnt_w-1:0]      r_cnt;
  logic [N_KEYS-1:0]       r_keypad;
  logic                    r_key_valid;
  logic [c_key_code_w-1:0] r_key_code;
  logic                    r_multi_err;
  logic                    r_multi_seen;

  // Next-state values
  state_t                  w_state_nxt;
  logic [N_KEYS-1:0]       w_cand_nxt;
  logic [c_cnt_w-1:0]      w_cnt_nxt;
  logic [N_KEYS-1:0]       w_keypad_nxt;
  logic                    w_key_valid_nxt;
  logic [c_key_code_w-1:0] w_key_code_nxt;
  logic                    w_multi_err_nxt;
  logic                    w_multi_seen_nxt;

  // Decoded synchronised inputs
  logic [N_KEYS-1:0]       w_sync;
  logic                    w_none;
  logic                    w_onehot;
  logic                    w_multi;
  logic                    w_match;
  logic [c_cnt_w-1:0]      w_cnt_inc;
  logic [c_key_code_w-1:0] w_cand_code;

  keypad_debouncer_sync2 #(
    .WIDTH (N_KEYS)
  ) u_sync2 (
    .clk     (clk),
    .clear_n (clear_n),
    .d       (bus.raw_keys),
    .q       (w_sync)
  );

  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign w_none    = (w_sync == '0);
  assign w_onehot  = !w_none && ((w_sync & (w_sync - N_KEYS'(1))) == '0);
  assign w_multi   = !w_none && !w_onehot;
  assign w_match   = (w_sync == r_cand);
  // Saturating increment: the counter parks at all-ones rather than wrapping.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + c_cnt_w'(1);

  // Priority-free encode: r_cand is one-hot whenever it is used, so OR-ing
  // the indices of set bits gives the key index directly.
  always_comb begin
    w_cand_code = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (r_cand[i]) begin
        w_cand_code = w_cand_code | c_key_code_w'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state      <= c_st_idle;
      r_cand       <= '0;
      r_cnt        <= '0;
      r_keypad     <= '0;
      r_key_valid  <= 1'b0;
      r_key_code   <= '0;
      r_multi_err  <= 1'b0;
      r_multi_seen <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cand       <= w_cand_nxt;
      r_cnt        <= w_cnt_nxt;
      r_keypad     <= w_keypad_nxt;
      r_key_valid  <= w_key_valid_nxt;
      r_key_code   <= w_key_code_nxt;
      r_multi_err  <= w_multi_err_nxt;
      r_multi_seen <= w_multi_seen_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt      = r_state;
    w_cand_nxt       = r_cand;
    w_cnt_nxt        = r_cnt;
    w_keypad_nxt     = r_keypad;
    w_key_valid_nxt  = 1'b0;
    w_key_code_nxt   = r_key_code;
    w_multi_err_nxt  = 1'b0;
    w_multi_seen_nxt = 1'b0;

    case (r_state)
      c_st_idle: begin
        // Remember a multi-key pattern so the error fires only on its first cycle.
        w_multi_seen_nxt = w_multi;
        if (w_onehot) begin
          w_state_nxt = c_st_arm;
          w_cand_nxt  = w_sync;
          w_cnt_nxt   = '0;
        end else if (w_multi && !r_multi_seen) begin
          w_multi_err_nxt = 1'b1;
        end
      end

      c_st_arm: begin
        if (w_match) begin
          if (r_cnt == c_deb_last) begin
            w_state_nxt     = c_st_held;
            w_keypad_nxt    = r_cand;
            w_key_code_nxt  = w_cand_code;
            w_key_valid_nxt = 1'b1;
            // Counter is reused as the repeat timer while held.
            w_cnt_nxt       = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else if (w_onehot) begin
          w_cand_nxt = w_sync;
          w_cnt_nxt  = '0;
        end else begin
          w_state_nxt = c_st_idle;
          w_cnt_nxt   = '0;
        end
      end

      c_st_held: begin
        if (!w_match) begin
          // Release or an added key: drop the level and wait for a clean release.
          w_state_nxt  = c_st_release;
          w_keypad_nxt = '0;
          w_cnt_nxt    = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (r_cnt == c_rpt_last) begin
          // One-cycle gap in keypad gives the downstream counter a fresh edge.
          w_cnt_nxt       = '0;
          w_key_valid_nxt = 1'b1;
          w_keypad_nxt    = '0;
        end else begin
          w_cnt_nxt    = w_cnt_inc;
          w_keypad_nxt = r_cand;
        end
`endif
      end

      c_st_release: begin
        if (w_none) begin
          if (r_cnt == c_deb_last) begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end

      default: begin
        w_state_nxt  = c_st_idle;
        w_cnt_nxt    = '0;
        w_keypad_nxt = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.keypad    = r_keypad;
    bus.key_valid = r_key_valid;
    bus.key_code  = r_key_code;
    bus.multi_err = r_multi_err;
  end

endmodule : keypad_debouncer
`default_nettype wire
